// File: rtl/ai_paddle_pkg.sv
// Shared game constants for the ping-pong court, plus the per-frame
// snapshot record the top paddle tracks against.
package ai_paddle_pkg;

  // Court bounds shared by the ball and the paddles
  localparam int COURT_X_MIN   = 51;
  localparam int COURT_X_MAX   = 108;

  // Paddle geometry: 8 px wide, 2 rows tall, walked pixel by pixel
  localparam int PADDLE_W      = 8;
  localparam int PADDLE_H      = 2;
  localparam int PADDLE_PIXELS = PADDLE_W * PADDLE_H;

  // Colour constants
  localparam logic [2:0] COLOR_BLACK = 3'b000;
  localparam logic [2:0] COLOR_WHITE = 3'b111;

  // Ball state frozen at frame start so mid-frame ball updates are ignored
  typedef struct packed {
    logic [7:0] ball_x;
    logic       ball_y_dir;
    logic       hard;
  } ball_snap_t;

endpackage

// File: rtl/ai_paddle_tracker.sv
// Combinational tracking decision: picks the target column, then steps the
// paddle left edge by at most one pixel toward it, clamped to the court.
module paddle_tracker
  import ai_paddle_pkg::*;
#(
  parameter int X_MIN  = COURT_X_MIN,
  parameter int X_MAX  = COURT_X_MAX,
  parameter int HOME_X = 76
) (
  input  logic [7:0] x_cur_i,
  input  ball_snap_t snap_i,
  input  logic       skip_i,
  output logic [7:0] x_next_o
);

  logic [8:0] target;
  logic [8:0] pc;
  logic       step_en;

  // Compare target against paddle centre in 9 bits so ball_x+2 cannot wrap
  always_comb begin
    target   = snap_i.ball_y_dir ? 9'(HOME_X + 4)
                                 : ({1'b0, snap_i.ball_x} + 9'd2);
    pc       = {1'b0, x_cur_i} + 9'd4;
    step_en  = snap_i.hard | ~skip_i;
    x_next_o = x_cur_i;
    if (step_en) begin
      if ((target > pc) && (x_cur_i < 8'(X_MAX - (PADDLE_W - 1)))) begin
        x_next_o = x_cur_i + 8'd1;
      end else if ((target < pc) && (x_cur_i > 8'(X_MIN))) begin
        x_next_o = x_cur_i - 8'd1;
      end
    end
  end

endmodule

// File: rtl/ai_paddle_top.sv
// Computer-controlled top paddle. Each frame: erase the old paddle, take one
// tracking step toward the ball, redraw, then pulse done.
module ai_paddle_top
  import ai_paddle_pkg::*;
#(
  parameter int         X_MIN        = COURT_X_MIN,
  parameter int         X_MAX        = COURT_X_MAX,
  parameter int         PADDLE_Y     = 9,
  parameter int         HOME_X       = 76,
  parameter logic [2:0] PADDLE_COLOR = COLOR_WHITE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic       difficulty,
  input  logic [7:0] ball_x,
  input  logic [6:0] ball_y,
  input  logic       ball_x_dir,
  input  logic       ball_y_dir,
  output logic [7:0] x_paddle_top,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] color_out,
  output logic       writeEn,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_MOVE,
    S_DRAW,
    S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] x_q, x_d;
  logic       skip_q, skip_d;
  ball_snap_t snap_q, snap_d;
  logic [7:0] x_next;
  logic       last_pix;

  // ball_y and ball_x_dir are carried for debug/extension only
  logic unused_ball;
  assign unused_ball = ^{ball_y, ball_x_dir};

  assign last_pix = (cnt_q == 4'(PADDLE_PIXELS - 1));

  paddle_tracker #(
    .X_MIN  (X_MIN),
    .X_MAX  (X_MAX),
    .HOME_X (HOME_X)
  ) u_tracker (
    .x_cur_i  (x_q),
    .snap_i   (snap_q),
    .skip_i   (skip_q),
    .x_next_o (x_next)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; go is only looked at in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (go) state_d = S_ERASE;
      S_ERASE: if (last_pix) state_d = S_MOVE;
      S_MOVE:  state_d = S_DRAW;
      S_DRAW:  if (last_pix) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: pixel strobe only while walking the paddle
  always_comb begin
    writeEn   = 1'b0;
    color_out = COLOR_BLACK;
    done      = 1'b0;
    case (state_q)
      S_ERASE: begin
        writeEn   = 1'b1;
        color_out = COLOR_BLACK;
      end
      S_DRAW: begin
        writeEn   = 1'b1;
        color_out = PADDLE_COLOR;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state: snapshot on go, pixel counter, single MOVE update
  always_comb begin
    cnt_d  = cnt_q;
    x_d    = x_q;
    skip_d = skip_q;
    snap_d = snap_q;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          snap_d.ball_x     = ball_x;
          snap_d.ball_y_dir = ball_y_dir;
          snap_d.hard       = difficulty;
          cnt_d             = 4'd0;
        end
      end
      S_ERASE, S_DRAW: cnt_d = cnt_q + 4'd1;
      S_MOVE: begin
        x_d    = x_next;
        skip_d = ~skip_q;
        cnt_d  = 4'd0;
      end
      default: ;
    endcase
  end

  // Paddle position, pixel counter and skip flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q    <= 8'(HOME_X);
      cnt_q  <= 4'd0;
      skip_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      cnt_q  <= cnt_d;
      skip_q <= skip_d;
    end
  end

  // Ball snapshot is pure data and is always rewritten before it is used
  always_ff @(posedge clk) begin
    snap_q <= snap_d;
  end

  assign x_paddle_top = x_q;
  assign x_out        = x_q + {5'd0, cnt_q[2:0]};
  assign y_out        = 7'(PADDLE_Y) + {6'd0, cnt_q[3]};

endmodule

// File: tb/tb_ai_paddle_top.sv
// Bench for ai_paddle_top: frame-level reference model of paddle tracking.
module tb_ai_paddle_top;

  logic       clk = 1'b0;
  logic       reset, go, difficulty;
  logic [7:0] ball_x;
  logic [6:0] ball_y;
  logic       ball_x_dir, ball_y_dir;
  logic [7:0] x_paddle_top, x_out;
  logic [6:0] y_out;
  logic [2:0] color_out;
  logic       writeEn, done;

  ai_paddle_top dut (
    .clk(clk), .reset(reset), .go(go), .difficulty(difficulty),
    .ball_x(ball_x), .ball_y(ball_y), .ball_x_dir(ball_x_dir),
    .ball_y_dir(ball_y_dir), .x_paddle_top(x_paddle_top), .x_out(x_out),
    .y_out(y_out), .color_out(color_out), .writeEn(writeEn), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: paddle left edge and alternate-frame flag
  int mdl_x    = 76;
  bit mdl_skip = 1'b0;

  // Observations of the last frame
  int nwr, done_cyc, x_pre, x_post;
  bit x_unstable;
  int wr_cyc[64], wr_x[64], wr_y[64], wr_c[64];

  // One frame of the game rules: move one pixel toward the target if allowed
  task automatic model_frame(input int bx, input bit ydir, input bit hard);
    int target;
    int centre;
    target = ydir ? (76 + 4) : (bx + 2);
    centre = mdl_x + 4;
    if (hard || !mdl_skip) begin
      if (target > centre && mdl_x < 108 - 7)      mdl_x = mdl_x + 1;
      else if (target < centre && mdl_x > 51)      mdl_x = mdl_x - 1;
    end
    mdl_skip = !mdl_skip;
  endtask

  task automatic set_ball(input int bx, input bit ydir, input bit hard);
    ball_x     = 8'(bx);
    ball_y_dir = ydir;
    difficulty = hard;
    ball_y     = 7'($urandom);
    ball_x_dir = 1'($urandom);
  endtask

  // Run one frame from IDLE and record what the DUT did, cycle by cycle
  task automatic do_frame(input bit hold_go, input bit poke_draw, input bit scramble);
    int x0;
    nwr = 0; done_cyc = -1; x_unstable = 1'b0; x_post = -1;
    @(negedge clk);
    go = 1'b1;
    x0 = int'(x_paddle_top);
    x_pre = x0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (!hold_go) go = poke_draw && (c == 20 || c == 26);
      if (scramble) begin
        ball_x = 8'($urandom); ball_y_dir = 1'($urandom); difficulty = 1'($urandom);
      end
      if (writeEn && nwr < 64) begin
        wr_cyc[nwr] = c; wr_x[nwr] = int'(x_out);
        wr_y[nwr] = int'(y_out); wr_c[nwr] = int'(color_out);
        nwr++;
      end
      if (c <= 17 && int'(x_paddle_top) != x0) x_unstable = 1'b1;
      if (done) begin
        done_cyc = c;
        x_post = int'(x_paddle_top);
        break;
      end
    end
    if (!hold_go) go = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; go = 1'b0;
    set_ball(78, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    checks++; if (x_paddle_top !== 8'd76) begin errors++; $display("FAIL reset_x got %0d want 76", x_paddle_top); end
    checks++; if (writeEn !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", writeEn); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (color_out !== 3'b000) begin errors++; $display("FAIL reset_color got %0d want 0", color_out); end
    checks++; if (x_out !== 8'd76) begin errors++; $display("FAIL reset_xout got %0d want 76", x_out); end
    checks++; if (y_out !== 7'd9) begin errors++; $display("FAIL reset_yout got %0d want 9", y_out); end
    reset = 1'b0;
    mdl_x = 76; mdl_skip = 1'b0;
  endtask

  task automatic test_first_frame();
    int bad; int old_x;
    set_ball(78, 1'b0, 1'b1);
    old_x = mdl_x;
    model_frame(78, 1'b0, 1'b1);
    do_frame(1'b0, 1'b0, 1'b0);
    bad = 0;
    for (int i = 0; i < 32 && i < nwr; i++) begin
      int ex, ey, ec, ecyc;
      ex   = (i < 16 ? old_x : mdl_x) + (i % 8);
      ey   = 9 + (i % 16) / 8;
      ec   = (i < 16) ? 0 : 7;
      ecyc = (i < 16) ? i + 1 : i + 2;
      if (wr_x[i] != ex || wr_y[i] != ey || wr_c[i] != ec || wr_cyc[i] != ecyc) bad++;
    end
    checks++; if (bad !== 0 || nwr !== 32) begin errors++; $display("FAIL first_pixels got bad=%0d writes=%0d want bad=0 writes=32", bad, nwr); end
    checks++; if (done_cyc !== 34) begin errors++; $display("FAIL first_done_cycle got %0d want 34", done_cyc); end
    checks++; if (x_post !== mdl_x) begin errors++; $display("FAIL first_x got %0d want %0d", x_post, mdl_x); end
  endtask

  task automatic test_track_hard();
    set_ball(100, 1'b0, 1'b1);
    for (int f = 0; f < 10; f++) begin
      model_frame(100, 1'b0, 1'b1);
      do_frame(1'b0, 1'b0, 1'b0);
      checks++; if (x_post !== mdl_x) begin errors++; $display("FAIL hard_track f%0d got %0d want %0d", f, x_post, mdl_x); end
    end
    checks++; if (x_paddle_top !== 8'd86) begin errors++; $display("FAIL hard_final got %0d want 86", x_paddle_top); end
  endtask

  task automatic test_walls();
    set_ball(51, 1'b0, 1'b1);
    for (int f = 0; f < 40; f++) begin
      model_frame(51, 1'b0, 1'b1);
      do_frame(1'b0, 1'b0, 1'b0);
      checks++; if (x_post !== mdl_x) begin errors++; $display("FAIL left_wall f%0d got %0d want %0d", f, x_post, mdl_x); end
    end
    checks++; if (x_paddle_top !== 8'd51) begin errors++; $display("FAIL left_clamp got %0d want 51", x_paddle_top); end
    set_ball(108, 1'b0, 1'b1);
    for (int f = 0; f < 55; f++) begin
      model_frame(108, 1'b0, 1'b1);
      do_frame(1'b0, 1'b0, 1'b0);
      checks++; if (x_post !== mdl_x) begin errors++; $display("FAIL right_wall f%0d got %0d want %0d", f, x_post, mdl_x); end
    end
    checks++; if (x_paddle_top !== 8'd101) begin errors++; $display("FAIL right_clamp got %0d want 101", x_paddle_top); end
  endtask

  task automatic test_easy();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mdl_x = 76; mdl_skip = 1'b0;
    set_ball(100, 1'b0, 1'b0);
    for (int f = 0; f < 10; f++) begin
      model_frame(100, 1'b0, 1'b0);
      do_frame(1'b0, 1'b0, 1'b0);
      checks++; if (x_post !== mdl_x) begin errors++; $display("FAIL easy_track f%0d got %0d want %0d", f, x_post, mdl_x); end
    end
    checks++; if (x_paddle_top !== 8'd81) begin errors++; $display("FAIL easy_final got %0d want 81", x_paddle_top); end
  endtask

  task automatic test_return_home();
    bit stray;
    set_ball(100, 1'b0, 1'b1);
    while (mdl_x < 90) begin
      model_frame(100, 1'b0, 1'b1);
      do_frame(1'b0, 1'b0, 1'b0);
    end
    checks++; if (x_paddle_top !== 8'd90) begin errors++; $display("FAIL home_start got %0d want 90", x_paddle_top); end
    set_ball(0, 1'b1, 1'b1);
    for (int f = 0; f < 16; f++) begin
      model_frame(0, 1'b1, 1'b1);
      do_frame(1'b0, 1'b1, 1'b0);
      checks++; if (x_post !== mdl_x || done_cyc !== 34) begin
        errors++; $display("FAIL home_step f%0d got x=%0d done@%0d want x=%0d done@34", f, x_post, done_cyc, mdl_x);
      end
    end
    checks++; if (x_paddle_top !== 8'd76) begin errors++; $display("FAIL home_final got %0d want 76", x_paddle_top); end
    stray = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (writeEn) stray = 1'b1;
    end
    checks++; if (stray !== 1'b0) begin errors++; $display("FAIL draw_go_ignored got writes=1 want writes=0"); end
  endtask

  task automatic test_back_to_back();
    int bx; bit seen;
    bx = int'($urandom_range(40, 120));
    set_ball(bx, 1'b0, 1'b1);
    model_frame(bx, 1'b0, 1'b1);
    do_frame(1'b1, 1'b0, 1'b0);
    checks++; if (x_post !== mdl_x || done_cyc !== 34) begin
      errors++; $display("FAIL b2b_first got x=%0d done@%0d want x=%0d done@34", x_post, done_cyc, mdl_x);
    end
    @(negedge clk);
    checks++; if (writeEn !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap got we=%b want 0", writeEn); end
    @(negedge clk);
    go = 1'b0;
    checks++; if (writeEn !== 1'b1 || int'(x_out) !== mdl_x || color_out !== 3'b000) begin
      errors++; $display("FAIL b2b_restart got we=%b x=%0d c=%0d want we=1 x=%0d c=0", writeEn, x_out, color_out, mdl_x);
    end
    model_frame(bx, 1'b0, 1'b1);
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checks++; if (!seen || int'(x_paddle_top) !== mdl_x) begin
      errors++; $display("FAIL b2b_second got done=%b x=%0d want done=1 x=%0d", seen, x_paddle_top, mdl_x);
    end
  endtask

  task automatic test_random();
    int bad;
    for (int f = 0; f < 40; f++) begin
      int bx; bit yd, hd; int old_x;
      bx = int'($urandom_range(0, 255)); yd = 1'($urandom); hd = 1'($urandom);
      set_ball(bx, yd, hd);
      old_x = mdl_x;
      model_frame(bx, yd, hd);
      do_frame(1'b0, 1'b0, 1'b1);
      bad = 0;
      for (int i = 0; i < 32 && i < nwr; i++) begin
        int ex;
        ex = (i < 16 ? old_x : mdl_x) + (i % 8);
        if (wr_x[i] != ex || wr_y[i] != 9 + (i % 16) / 8 || wr_c[i] != ((i < 16) ? 0 : 7)) bad++;
      end
      checks++; if (bad !== 0 || nwr !== 32 || done_cyc !== 34 || x_unstable) begin
        errors++; $display("FAIL rand_frame f%0d got bad=%0d writes=%0d done@%0d unstable=%b want 0/32/34/0", f, bad, nwr, done_cyc, x_unstable);
      end
      checks++; if (x_post !== mdl_x) begin errors++; $display("FAIL rand_x f%0d got %0d want %0d", f, x_post, mdl_x); end
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    set_ball(120, 1'b0, 1'b1);
    @(negedge clk);
    go = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      go = 1'b0;
    end
    checks++; if (writeEn !== 1'b1) begin errors++; $display("FAIL mid_pre_we got %b want 1", writeEn); end
    reset = 1'b1;
    #1;
    checks++; if (writeEn !== 1'b0 || x_paddle_top !== 8'd76) begin
      errors++; $display("FAIL mid_reset got we=%b x=%0d want we=0 x=76", writeEn, x_paddle_top);
    end
    @(negedge clk);
    reset = 1'b0;
    mdl_x = 76; mdl_skip = 1'b0;
    set_ball(78, 1'b0, 1'b1);
    model_frame(78, 1'b0, 1'b1);
    do_frame(1'b0, 1'b0, 1'b0);
    bad = 0;
    for (int i = 0; i < 16 && i < nwr; i++) begin
      if (wr_x[i] != 76 + (i % 8) || wr_c[i] != 0) bad++;
    end
    checks++; if (bad !== 0 || nwr !== 32) begin errors++; $display("FAIL mid_next_erase got bad=%0d writes=%0d want bad=0 writes=32", bad, nwr); end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_track_hard();
    test_walls();
    test_easy();
    test_return_home();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
